// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store sequencer. Drives a req/gnt/rvalid data-memory
//               port, stalls the core while an access is in flight, returns
//               aligned and extended load data, and flags misaligned/illegal
//               accesses and memory timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_mac,
    input  logic [1:0]  loadstore_mac,
    input  logic [2:0]  funct3_mac,
    input  logic [31:0] addr_mac,
    input  logic [31:0] wdata_mac,
    output logic        stall_mac,
    output logic        done_mac,
    output logic [31:0] rdata_mac,
    output logic        misalign_mac,
    output logic        timeout_mac,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_LS_LOAD  = 2'b01;
    localparam logic [1:0] c_LS_STORE = 2'b10;
    localparam logic [7:0] c_CNT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT_R = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [7:0]  r_cnt;
    logic        r_tmo;
    logic [31:0] r_rdata;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_accept;
    logic        w_legal;
    logic        w_aligned;
    logic [31:0] w_lane;
    logic [31:0] w_ext;

    assign w_is_load  = (loadstore_mac == c_LS_LOAD);
    assign w_is_store = (loadstore_mac == c_LS_STORE);
    assign w_accept   = start_mac & (w_is_load | w_is_store);

    // Decode legality of funct3 for the issued class and check natural alignment
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b1;
        if (w_is_load) begin
            w_legal = (funct3_mac == 3'b000) | (funct3_mac == 3'b001) |
                      (funct3_mac == 3'b010) | (funct3_mac == 3'b100) |
                      (funct3_mac == 3'b101);
        end else if (w_is_store) begin
            w_legal = (funct3_mac == 3'b000) | (funct3_mac == 3'b001) |
                      (funct3_mac == 3'b010);
        end
        if (funct3_mac[1:0] == 2'b01) begin
            w_aligned = (addr_mac[0] == 1'b0);
        end else if (funct3_mac[1:0] == 2'b10) begin
            w_aligned = (addr_mac[1:0] == 2'b00);
        end
    end

    // Shift the addressed lane down and extend it according to the load width
    always_comb begin
        w_lane = mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'd0, w_lane[7:0]};
            3'b101:  w_ext = {16'd0, w_lane[15:0]};
            default: w_ext = mem_rdata;
        endcase
    end

    // Next-state logic; a handshake in the last allowed cycle beats the timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_legal && w_aligned) ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_next_state = r_we ? S_DONE : S_WAIT_R;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = S_ERR;
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    w_next_state = S_DONE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next_state = S_ERR;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            S_ERR:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register plus latched request, wait counter, error cause and load result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= 32'd0;
            r_funct3 <= 3'd0;
            r_wdata  <= 32'd0;
            r_we     <= 1'b0;
            r_cnt    <= 8'd0;
            r_tmo    <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_accept) begin
                r_addr   <= addr_mac;
                r_funct3 <= funct3_mac;
                r_wdata  <= wdata_mac;
                r_we     <= w_is_store;
                r_tmo    <= 1'b0;
            end
            if (w_next_state != r_state) begin
                r_cnt <= 8'd0;
            end else if (r_state == S_REQ || r_state == S_WAIT_R) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if ((r_state == S_REQ || r_state == S_WAIT_R) && w_next_state == S_ERR) begin
                r_tmo <= 1'b1;
            end
            if (r_state == S_WAIT_R && mem_rvalid) begin
                r_rdata <= w_ext;
            end
        end
    end

    // Port outputs decoded from the current state; memory fields are zero outside REQ
    always_comb begin
        stall_mac    = (r_state != S_IDLE) | w_accept;
        done_mac     = (r_state == S_DONE);
        misalign_mac = (r_state == S_ERR) & ~r_tmo;
        timeout_mac  = (r_state == S_ERR) & r_tmo;
        rdata_mac    = r_rdata;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'b0000;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        if (r_state == S_REQ) begin
            mem_req  = 1'b1;
            mem_we   = r_we;
            mem_addr = {r_addr[31:2], 2'b00};
            case (r_funct3[1:0])
                2'b00: begin
                    mem_be    = 4'b0001 << r_addr[1:0];
                    mem_wdata = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    mem_be    = 4'b0011 << {r_addr[1], 1'b0};
                    mem_wdata = {2{r_wdata[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = r_wdata;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl (MAX_WAIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_mac;
    logic [1:0]  loadstore_mac;
    logic [2:0]  funct3_mac;
    logic [31:0] addr_mac;
    logic [31:0] wdata_mac;
    logic        stall_mac;
    logic        done_mac;
    logic [31:0] rdata_mac;
    logic        misalign_mac;
    logic        timeout_mac;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_err;

    mem_access_ctrl #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_mac(start_mac), .loadstore_mac(loadstore_mac),
        .funct3_mac(funct3_mac), .addr_mac(addr_mac), .wdata_mac(wdata_mac),
        .stall_mac(stall_mac), .done_mac(done_mac), .rdata_mac(rdata_mac),
        .misalign_mac(misalign_mac), .timeout_mac(timeout_mac),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] ls, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        start_mac     = 1'b1;
        loadstore_mac = ls;
        funct3_mac    = f3;
        addr_mac      = a;
        wdata_mac     = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_mac = 1'b0; loadstore_mac = 2'b00; funct3_mac = 3'd0;
        addr_mac = 32'd0; wdata_mac = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        #12;
        n_cmp++;
        if ({stall_mac, done_mac, misalign_mac, timeout_mac, mem_req, mem_we} !== 6'd0) begin
            n_err++; $display("FAIL reset_ctrl got %b want 000000",
                {stall_mac, done_mac, misalign_mac, timeout_mac, mem_req, mem_we});
        end
        n_cmp++;
        if ({rdata_mac, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
            n_err++; $display("FAIL reset_data got %h/%h/%h/%h want 0",
                rdata_mac, mem_addr, mem_wdata, mem_be);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        // start with a non-memory class must not stall
        issue(2'b00, 3'b000, 32'h0, 32'h0); #1;
        n_cmp++;
        if (stall_mac !== 1'b0) begin n_err++; $display("FAIL class_none_stall got %b want 0", stall_mac); end
        tick();
        start_mac = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b0) begin n_err++; $display("FAIL class_none_req got %b want 0", mem_req); end
    endtask

    task automatic test_store_byte();
        issue(2'b10, 3'b000, 32'h0000_1003, 32'h0000_00A5); #1;
        n_cmp++;
        if ({stall_mac, mem_req} !== 2'b10) begin n_err++; $display("FAIL sb_issue stall/req got %b want 10", {stall_mac, mem_req}); end
        tick();
        start_mac = 1'b0; mem_gnt = 1'b1; #1;
        n_cmp++;
        if ({mem_req, mem_we, mem_be} !== 6'b11_1000) begin
            n_err++; $display("FAIL sb_req req/we/be got %b want 111000", {mem_req, mem_we, mem_be});
        end
        n_cmp++;
        if (mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hA5A5_A5A5) begin
            n_err++; $display("FAIL sb_addr_data got %h/%h want 00001000/a5a5a5a5", mem_addr, mem_wdata);
        end
        tick();
        mem_gnt = 1'b0; #1;
        n_cmp++;
        if ({done_mac, stall_mac, mem_req} !== 3'b110) begin
            n_err++; $display("FAIL sb_done done/stall/req got %b want 110", {done_mac, stall_mac, mem_req});
        end
        tick();
        n_cmp++;
        if ({done_mac, stall_mac} !== 2'b00) begin n_err++; $display("FAIL sb_idle done/stall got %b want 00", {done_mac, stall_mac}); end
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] expv);
        issue(2'b01, f3, 32'h0000_2001, 32'h0); #1;
        n_cmp++;
        if (stall_mac !== 1'b1) begin n_err++; $display("FAIL lb%0d_issue_stall got %b want 1", f3, stall_mac); end
        tick();
        start_mac = 1'b0; mem_gnt = 1'b1; #1;
        n_cmp++;
        if ({mem_req, mem_we, stall_mac, mem_addr} !== {3'b101, 32'h0000_2000}) begin
            n_err++; $display("FAIL lb%0d_req req/we/stall/addr got %b%b%b/%h want 101/00002000",
                f3, mem_req, mem_we, stall_mac, mem_addr);
        end
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_8000; #1;
        n_cmp++;
        if ({mem_req, stall_mac, done_mac} !== 3'b010) begin
            n_err++; $display("FAIL lb%0d_wait req/stall/done got %b want 010", f3, {mem_req, stall_mac, done_mac});
        end
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        n_cmp++;
        if ({done_mac, stall_mac} !== 2'b11 || rdata_mac !== expv) begin
            n_err++; $display("FAIL lb%0d_done done/stall/rdata got %b/%h want 11/%h",
                f3, {done_mac, stall_mac}, rdata_mac, expv);
        end
        tick();
        n_cmp++;
        if ({done_mac, stall_mac} !== 2'b00 || rdata_mac !== expv) begin
            n_err++; $display("FAIL lb%0d_hold done/stall/rdata got %b/%h want 00/%h",
                f3, {done_mac, stall_mac}, rdata_mac, expv);
        end
    endtask

    task automatic test_misalign(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] keep);
        int reqs = 0;
        issue(2'b01, f3, a, 32'h0); #1;
        if (mem_req) reqs++;
        n_cmp++;
        if (stall_mac !== 1'b1) begin n_err++; $display("FAIL mis_f3%0d_stall got %b want 1", f3, stall_mac); end
        tick();
        start_mac = 1'b0; #1;
        if (mem_req) reqs++;
        n_cmp++;
        if ({misalign_mac, timeout_mac, done_mac, stall_mac} !== 4'b1001) begin
            n_err++; $display("FAIL mis_f3%0d_err mis/tmo/done/stall got %b want 1001",
                f3, {misalign_mac, timeout_mac, done_mac, stall_mac});
        end
        tick();
        if (mem_req) reqs++;
        n_cmp++;
        if ({misalign_mac, done_mac, stall_mac} !== 3'b000 || rdata_mac !== keep || reqs != 0) begin
            n_err++; $display("FAIL mis_f3%0d_after mis/done/stall/rdata/reqs got %b/%h/%0d want 000/%h/0",
                f3, {misalign_mac, done_mac, stall_mac}, rdata_mac, reqs, keep);
        end
    endtask

    task automatic test_gnt_delay();
        // SH at 0x3002: upper half lane; gnt arrives in the last allowed REQ cycle
        issue(2'b10, 3'b001, 32'h0000_3002, 32'h1234_5678);
        tick();
        start_mac = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3); #1;
            n_cmp++;
            if ({mem_req, mem_we, mem_be} !== 6'b11_1100 || mem_addr !== 32'h0000_3000 ||
                mem_wdata !== 32'h5678_5678 || timeout_mac !== 1'b0) begin
                n_err++; $display("FAIL sh_stable_c%0d req/we/be/addr/wdata/tmo got %b/%h/%h/%b want 111100/00003000/56785678/0",
                    i, {mem_req, mem_we, mem_be}, mem_addr, mem_wdata, timeout_mac);
            end
            tick();
        end
        mem_gnt = 1'b0; #1;
        n_cmp++;
        if ({done_mac, timeout_mac} !== 2'b10) begin
            n_err++; $display("FAIL sh_done done/tmo got %b want 10", {done_mac, timeout_mac});
        end
        tick();
        // LHU at 0x3002
        issue(2'b01, 3'b101, 32'h0000_3002, 32'h0);
        tick();
        start_mac = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_1234;
        tick();
        mem_rvalid = 1'b0; #1;
        n_cmp++;
        if (done_mac !== 1'b1 || rdata_mac !== 32'h0000_BEEF) begin
            n_err++; $display("FAIL lhu_done done/rdata got %b/%h want 1/0000beef", done_mac, rdata_mac);
        end
        tick();
    endtask

    task automatic test_timeout(input logic is_load);
        int reqs  = 0;
        int waits = 0;
        logic seen = 1'b0;
        issue(is_load ? 2'b01 : 2'b10, 3'b010, 32'h0000_4000, 32'h1111_2222);
        tick();
        start_mac = 1'b0;
        mem_gnt = is_load;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (timeout_mac) begin seen = 1'b1; break; end
            if (mem_req) reqs++;
            else if (stall_mac) waits++;
            tick();
            mem_gnt = 1'b0;
        end
        n_cmp++;
        if (seen !== 1'b1 || reqs != (is_load ? 1 : 4) || waits != (is_load ? 4 : 0)) begin
            n_err++; $display("FAIL timeout_ld%0d seen/reqs/waits got %b/%0d/%0d want 1/%0d/%0d",
                is_load, seen, reqs, waits, is_load ? 1 : 4, is_load ? 4 : 0);
        end
        n_cmp++;
        if ({misalign_mac, done_mac, mem_req} !== 3'b000) begin
            n_err++; $display("FAIL timeout_ld%0d_flags mis/done/req got %b want 000",
                is_load, {misalign_mac, done_mac, mem_req});
        end
        tick();
        n_cmp++;
        if ({timeout_mac, stall_mac} !== 2'b00 || rdata_mac !== 32'h0000_BEEF) begin
            n_err++; $display("FAIL timeout_ld%0d_idle tmo/stall/rdata got %b/%h want 00/0000beef",
                is_load, {timeout_mac, stall_mac}, rdata_mac);
        end
    endtask

    task automatic test_reset_mid();
        issue(2'b01, 3'b010, 32'h0000_6000, 32'h0);
        tick();
        start_mac = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; #2;
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({stall_mac, mem_req, done_mac} !== 3'b000 || rdata_mac !== 32'h0) begin
            n_err++; $display("FAIL rstmid_async stall/req/done/rdata got %b/%h want 000/00000000",
                {stall_mac, mem_req, done_mac}, rdata_mac);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0; #1;
        n_cmp++;
        if ({stall_mac, done_mac} !== 2'b00 || rdata_mac !== 32'h0) begin
            n_err++; $display("FAIL rstmid_rvalid stall/done/rdata got %b/%h want 00/00000000",
                {stall_mac, done_mac}, rdata_mac);
        end
        issue(2'b10, 3'b010, 32'h0000_7000, 32'hCAFE_F00D);
        tick();
        start_mac = 1'b0; mem_gnt = 1'b1; #1;
        n_cmp++;
        if ({mem_req, mem_we, mem_be} !== 6'b11_1111 || mem_addr !== 32'h0000_7000 || mem_wdata !== 32'hCAFE_F00D) begin
            n_err++; $display("FAIL sw_after_rst req/we/be/addr/wdata got %b/%h/%h want 111111/00007000/cafef00d",
                {mem_req, mem_we, mem_be}, mem_addr, mem_wdata);
        end
        tick();
        mem_gnt = 1'b0; #1;
        n_cmp++;
        if (done_mac !== 1'b1) begin n_err++; $display("FAIL sw_after_rst_done got %b want 1", done_mac); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_store_byte();
        test_load_byte(3'b000, 32'hFFFF_FF80);
        test_load_byte(3'b100, 32'h0000_0080);
        test_misalign(3'b010, 32'h0000_2002, 32'h0000_0080);
        test_misalign(3'b011, 32'h0000_2000, 32'h0000_0080);
        test_gnt_delay();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
